// File: rtl/i2lbs_scan_ctrl.sv
// i2lbs_scan_ctrl: raster window-scan controller that sequences classifier stages
// per complete window with early reject and reports surviving windows.
module i2lbs_scan_ctrl #(
    parameter int DATA_WIDTH_12 = 12,
    parameter int FRAME_WIDTH   = 10,
    parameter int FRAME_HEIGHT  = 10,
    parameter int WINDOW_WIDTH  = 3,
    parameter int WINDOW_HEIGHT = 3,
    parameter int NUM_STAGES    = 24,
    parameter int STAGE_IDX_W   = 5,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_enable,
    input  logic                     i_pixel_valid,
    output logic                     o_pixel_ready,
    input  logic                     i_window_ready,
    output logic                     o_stage_start,
    output logic [STAGE_IDX_W-1:0]   o_stage_index,
    input  logic                     i_stage_done,
    input  logic                     i_stage_pass,
    output logic                     o_candidate,
    output logic [DATA_WIDTH_12-1:0] o_candidate_x,
    output logic [DATA_WIDTH_12-1:0] o_candidate_y,
    output logic [COUNT_WIDTH-1:0]   o_candidate_count,
    output logic                     o_frame_done,
    output logic                     o_busy
);
    typedef enum logic [2:0] {RECEIVE, WAIT_WINDOW, STAGE_ISSUE, STAGE_WAIT, REPORT} state_t;
    state_t state, state_next;
    logic [DATA_WIDTH_12-1:0] x, y, cand_x, cand_y;
    logic last_pixel, accept, reach, at_eol, at_eof, last_stage, reject, back;
    assign o_pixel_ready = (state == RECEIVE) && i_enable && reset_fpga;
    assign accept        = i_pixel_valid && o_pixel_ready;
    assign at_eol        = x == DATA_WIDTH_12'(FRAME_WIDTH - 1);
    assign at_eof        = at_eol && (y == DATA_WIDTH_12'(FRAME_HEIGHT - 1));
    assign reach         = (x >= DATA_WIDTH_12'(WINDOW_WIDTH - 1)) && (y >= DATA_WIDTH_12'(WINDOW_HEIGHT - 1));
    assign last_stage    = o_stage_index == STAGE_IDX_W'(NUM_STAGES - 1);
    assign reject        = (state == STAGE_WAIT) && i_stage_done && !i_stage_pass;
    assign back          = reject || (state == REPORT);
    assign o_stage_start = state == STAGE_ISSUE;
    assign o_busy        = state != RECEIVE;
    always_comb begin
        state_next = state;
        case (state)
            RECEIVE:     state_next = (accept && reach) ? WAIT_WINDOW : RECEIVE;
            WAIT_WINDOW: state_next = i_window_ready ? STAGE_ISSUE : WAIT_WINDOW;
            STAGE_ISSUE: state_next = STAGE_WAIT;
            STAGE_WAIT:  state_next = !i_stage_done ? STAGE_WAIT :
                                      !i_stage_pass ? RECEIVE :
                                      last_stage    ? REPORT : STAGE_ISSUE;
            REPORT:      state_next = RECEIVE;
            default:     state_next = RECEIVE;
        endcase
    end
    always_ff @(posedge clk_fpga) begin
        if (!reset_fpga) begin
            state             <= RECEIVE;
            x                 <= '0;
            y                 <= '0;
            cand_x            <= '0;
            cand_y            <= '0;
            last_pixel        <= 1'b0;
            o_stage_index     <= '0;
            o_candidate       <= 1'b0;
            o_candidate_x     <= '0;
            o_candidate_y     <= '0;
            o_candidate_count <= '0;
            o_frame_done      <= 1'b0;
        end else begin
            state        <= state_next;
            o_candidate  <= state == REPORT;
            o_frame_done <= back && last_pixel;
            if (accept) begin
                x <= at_eol ? '0 : x + 1'b1;
                y <= at_eof ? '0 : (at_eol ? y + 1'b1 : y);
                if (reach) begin
                    cand_x     <= x - DATA_WIDTH_12'(WINDOW_WIDTH - 1);
                    cand_y     <= y - DATA_WIDTH_12'(WINDOW_HEIGHT - 1);
                    last_pixel <= at_eof;
                end
            end
            if (back)
                last_pixel <= 1'b0;
            if (state == WAIT_WINDOW && i_window_ready)
                o_stage_index <= '0;
            else if (state == STAGE_WAIT && i_stage_done && i_stage_pass && !last_stage)
                o_stage_index <= o_stage_index + 1'b1;
            if (state == REPORT) begin
                o_candidate_x     <= cand_x;
                o_candidate_y     <= cand_y;
                o_candidate_count <= (&o_candidate_count) ? o_candidate_count : o_candidate_count + 1'b1;
            end
            // count is per frame: cleared once the frame_done pulse has been seen
            if (o_frame_done)
                o_candidate_count <= '0;
        end
    end
endmodule

// File: tb/tb_i2lbs_scan_ctrl.sv
// tb_i2lbs_scan_ctrl: randomized directed bench for i2lbs_scan_ctrl against a
// pixel-count based reference model (8x6 frame, 3x3 window, 4 stages).
module tb_i2lbs_scan_ctrl;
    localparam int FW = 8, FH = 6, WW = 3, WH = 3, NS = 4, IW = 5, CW = 16, DW = 12;
    localparam int NPIX = FW * FH;
    logic clk = 0, reset_fpga = 0, i_enable = 0, i_pixel_valid = 0;
    logic i_window_ready = 0, i_stage_done = 0, i_stage_pass = 0;
    logic o_pixel_ready, o_stage_start, o_candidate, o_frame_done, o_busy;
    logic [IW-1:0] o_stage_index;
    logic [DW-1:0] o_candidate_x, o_candidate_y;
    logic [CW-1:0] o_candidate_count;
    int compared = 0, mismatched = 0;
    int pix_n = 0, exp_count = 0;

    i2lbs_scan_ctrl #(
        .DATA_WIDTH_12(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .WINDOW_WIDTH(WW),
        .WINDOW_HEIGHT(WH), .NUM_STAGES(NS), .STAGE_IDX_W(IW), .COUNT_WIDTH(CW)
    ) dut (
        .clk_fpga(clk), .reset_fpga(reset_fpga), .i_enable(i_enable), .i_pixel_valid(i_pixel_valid),
        .o_pixel_ready(o_pixel_ready), .i_window_ready(i_window_ready), .o_stage_start(o_stage_start),
        .o_stage_index(o_stage_index), .i_stage_done(i_stage_done), .i_stage_pass(i_stage_pass),
        .o_candidate(o_candidate), .o_candidate_x(o_candidate_x), .o_candidate_y(o_candidate_y),
        .o_candidate_count(o_candidate_count), .o_frame_done(o_frame_done), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_mask();
        logic [3:0] m;
        for (int b = 0; b < 4; b++) m[b] = ($urandom_range(0, 7) != 0);
        return m;
    endfunction

    // One pixel: accept it, then if it completes a window run the stage sequence.
    task automatic pixel(input logic [3:0] mask, input int abort_stage);
        int px, py, g, d, w;
        bit last;
        px = pix_n % FW;
        py = pix_n / FW;
        last = pix_n == NPIX - 1;
        g = $urandom_range(0, 2);
        i_pixel_valid = 1;
        repeat (g) begin
            i_enable = 0;
            #1 chk("ready_disabled", o_pixel_ready, 0);
            step();
        end
        i_enable = 1;
        #1 chk("ready", o_pixel_ready, 1);
        chk("idle_busy", o_busy, 0);
        step();
        i_pixel_valid = 0;
        pix_n = (pix_n + 1) % NPIX;
        if (!(px >= WW - 1 && py >= WH - 1)) begin
            chk("busy_noreach", o_busy, 0);
            return;
        end
        chk("busy", o_busy, 1);
        chk("ready_busy", o_pixel_ready, 0);
        d = $urandom_range(0, 2);
        i_window_ready = 0;
        repeat (d) begin
            chk("no_early_start", o_stage_start, 0);
            step();
        end
        chk("no_early_start", o_stage_start, 0);
        i_window_ready = 1;
        step();
        i_window_ready = 0;
        for (int s = 0; s < NS; s++) begin
            chk("stage_start", o_stage_start, 1);
            chk("stage_index", o_stage_index, s);
            i_stage_done = $urandom_range(0, 1);
            i_stage_pass = 0;
            step();
            i_stage_done = 0;
            chk("start_once", o_stage_start, 0);
            chk("wait_busy", o_busy, 1);
            w = $urandom_range(0, 2);
            repeat (w) step();
            if (s == abort_stage) begin
                reset_fpga = 0;
                step();
                chk("abort_busy", o_busy, 0);
                chk("abort_index", o_stage_index, 0);
                chk("abort_cand", o_candidate, 0);
                chk("abort_count", o_candidate_count, 0);
                reset_fpga = 1;
                i_stage_done = 1;
                i_stage_pass = 1;
                step();
                i_stage_done = 0;
                chk("late_done_busy", o_busy, 0);
                chk("late_done_start", o_stage_start, 0);
                chk("late_done_cand", o_candidate, 0);
                pix_n = 0;
                exp_count = 0;
                return;
            end
            i_stage_done = 1;
            i_stage_pass = mask[s];
            step();
            i_stage_done = 0;
            if (!mask[s]) begin
                chk("reject_ready", o_pixel_ready, 1);
                chk("reject_cand", o_candidate, 0);
                chk("reject_frame_done", o_frame_done, last);
                chk("reject_count", o_candidate_count, exp_count);
                break;
            end
        end
        if (mask[NS-1:0] == 4'hF) begin
            chk("report_busy", o_busy, 1);
            chk("report_cand_early", o_candidate, 0);
            step();
            exp_count++;
            chk("cand", o_candidate, 1);
            chk("cand_x", o_candidate_x, px - (WW - 1));
            chk("cand_y", o_candidate_y, py - (WH - 1));
            chk("cand_count", o_candidate_count, exp_count);
            chk("cand_frame_done", o_frame_done, last);
            chk("cand_ready", o_pixel_ready, 1);
        end
        if (last) begin
            step();
            chk("frame_done_once", o_frame_done, 0);
            chk("count_cleared", o_candidate_count, 0);
            exp_count = 0;
        end
    endtask

    initial begin
        reset_fpga = 0;
        i_pixel_valid = 1;
        i_enable = 1;
        repeat (3) begin
            step();
            chk("rst_ready", o_pixel_ready, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_start", o_stage_start, 0);
            chk("rst_index", o_stage_index, 0);
            chk("rst_cand", o_candidate, 0);
            chk("rst_cand_x", o_candidate_x, 0);
            chk("rst_cand_y", o_candidate_y, 0);
            chk("rst_count", o_candidate_count, 0);
            chk("rst_frame_done", o_frame_done, 0);
        end
        reset_fpga = 1;
        #1 chk("ready_after_reset", o_pixel_ready, 1);
        for (int i = 0; i < NPIX; i++)
            pixel(i == 18 || i == NPIX - 1 ? 4'hF : i == 19 ? 4'b1101 : rand_mask(), -1);
        for (int i = 0; i < NPIX; i++)
            pixel(rand_mask(), -1);
        for (int i = 0; i < 18; i++)
            pixel(rand_mask(), -1);
        pixel(4'hF, 2);
        for (int i = 0; i < 30; i++)
            pixel(rand_mask(), -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
